// File: rtl/mux_sel_ctrl_if.sv
// Button/mode inputs and select outputs of the mux select stage.
// The master side drives the button and mode; the slave side is the controller.
interface mux_sel_ctrl_if;
    logic btn_in;
    logic auto_en;
    logic sel_out;
    logic sel_changed;
    logic btn_level;

    modport master (
        output btn_in,
        output auto_en,
        input  sel_out,
        input  sel_changed,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        input  auto_en,
        output sel_out,
        output sel_changed,
        output btn_level
    );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Mux select generator: synchronised, debounced pushbutton toggles the select;
// an optional auto mode toggles it every AUTO_PERIOD cycles.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic           clk,
    input  logic           rst,
    mux_sel_ctrl_if.slave  bus
);
    localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW  = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(AUTO_PERIOD - 1);

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

    logic           sync1_q, sync2_q;
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           prev_level_q;
    logic           press;
    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic           sel_q;
    logic           chg_q;

    // Debounce: any sample equal to the accepted level restarts the count.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            prev_level_q <= 1'b0;
        end else begin
            sync1_q      <= bus.btn_in;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            prev_level_q <= level_q;
        end
    end

    assign press = level_q & ~prev_level_q;

    // A press and a timer terminal in the same cycle collapse into one toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            timer_q <= '0;
            sel_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                MANUAL: begin
                    timer_q <= '0;
                    if (press) begin
                        sel_q <= ~sel_q;
                        chg_q <= 1'b1;
                    end
                    if (bus.auto_en) state_q <= AUTO;
                end
                AUTO: begin
                    if (!bus.auto_en) begin
                        state_q <= MANUAL;
                        timer_q <= '0;
                        if (press) begin
                            sel_q <= ~sel_q;
                            chg_q <= 1'b1;
                        end
                    end else if (press || timer_q == T_LAST) begin
                        sel_q   <= ~sel_q;
                        chg_q   <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= MANUAL;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.sel_out     = sel_q;
    assign bus.sel_changed = chg_q;
    assign bus.btn_level   = level_q;
endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Bench for mux_sel_ctrl: directed scenarios plus randomized button/mode traffic,
// every cycle compared against an event-level model of the select behaviour.
module tb_mux_sel_ctrl;
    localparam int DB = 4;
    localparam int P  = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    mux_sel_ctrl_if bus ();

    mux_sel_ctrl #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: button samples in flight, accepted level, press history,
    // mode, and cycles elapsed since the auto period last restarted.
    bit m_samp[$];
    bit m_level, m_prev, m_auto, m_sel, m_chg;
    int m_disagree, m_since;

    task automatic model_reset();
        m_samp = '{1'b0, 1'b0};
        m_level = 0; m_prev = 0; m_auto = 0; m_sel = 0; m_chg = 0;
        m_disagree = 0; m_since = 0;
    endtask

    task automatic model_edge(input bit r, input bit b, input bit a);
        bit seen, press, tgl;
        if (r) begin
            model_reset();
            return;
        end
        press = m_level && !m_prev;
        seen  = m_samp[1];
        m_samp.push_front(b);
        void'(m_samp.pop_back());
        m_prev = m_level;
        // New level accepted after DB consecutive disagreeing samples.
        if (seen != m_level) begin
            m_disagree++;
            if (m_disagree == DB) begin
                m_level = seen;
                m_disagree = 0;
            end
        end else begin
            m_disagree = 0;
        end
        tgl = 0;
        if (!m_auto) begin
            tgl = press;
            m_since = 0;
            m_auto = a;
        end else if (!a) begin
            tgl = press;
            m_since = 0;
            m_auto = 0;
        end else begin
            m_since++;
            if (press || m_since == P) begin
                tgl = 1;
                m_since = 0;
            end
        end
        m_chg = tgl;
        m_sel = m_sel ^ tgl;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare all outputs.
    task automatic cyc(input bit r, input bit b, input bit a);
        rst = r;
        bus.btn_in = b;
        bus.auto_en = a;
        @(posedge clk);
        model_edge(r, b, a);
        #1;
        chk("sel_out", bus.sel_out, m_sel);
        chk("sel_changed", bus.sel_changed, m_chg);
        chk("btn_level", bus.btn_level, m_level);
    endtask

    initial begin
        int lat, pulses;
        logic sel0;
        bit b, a;
        model_reset();
        rst = 1'b1;
        bus.btn_in = 1'b1;
        bus.auto_en = 1'b1;

        // Reset held with button and auto asserted; outputs stay low.
        for (int i = 0; i < 3; i++) cyc(1, 1, 1);
        cyc(0, 0, 0);
        chk("post_reset_sel", bus.sel_out, 1'b0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);

        // Clean press: toggle about DB+3 edges after the rise, one pulse.
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 1, 0);
            if (bus.sel_changed) pulses++;
            if (lat == 0 && bus.sel_out) lat = i;
        end
        chk_int("press_latency", lat, DB + 2, DB + 4);
        chk_int("press_pulses", pulses, 1, 1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 0);
            if (bus.sel_changed) pulses++;
        end
        chk_int("release_pulses", pulses, 0, 0);

        // Bounce every 2 cycles, then settle high: exactly one toggle.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, ((i / 2) % 2) == 0, 0);
            if (bus.sel_changed) pulses++;
        end
        chk_int("bounce_pulses", pulses, 0, 0);
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 1, 0);
            if (bus.sel_changed) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        chk_int("settle_pulses", pulses, 1, 1);
        chk_int("settle_latency", lat, DB + 2, DB + 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);

        // Auto mode: toggles 8 and 16 cycles after entry, frozen once off.
        sel0 = bus.sel_out;
        pulses = 0;
        lat = 0;
        for (int i = 1; i <= 19; i++) begin
            cyc(0, 0, 1);
            if (bus.sel_changed) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        chk_int("auto_first_toggle", lat, P + 1, P + 1);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0);
            if (bus.sel_changed) pulses++;
        end
        chk_int("auto_pulses", pulses, 2, 2);
        chk("auto_frozen_sel", bus.sel_out, sel0);

        // Press while in auto mode, then mid-debounce and mid-timer resets.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("mid_reset_sel", bus.sel_out, 1'b0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1);

        // Randomized traffic: held button levels, mode flips, rare resets;
        // press/terminal collisions arise naturally and are model-checked.
        b = 0;
        a = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            if ($urandom_range(0, 40) == 0) a = ~a;
            cyc($urandom_range(0, 400) == 0, b, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
